// File: rtl/sys_cfg_arb.sv
// sys_cfg_arb: round-robin arbiter that lets two configuration masters share
// the single BRAM-style port of sys_cfg_wrap, one whole transaction at a time.
module sys_cfg_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = DATA_WIDTH / 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  m0_req,
    input  logic [BYTE_NUM-1:0]   m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic [BYTE_NUM-1:0]   m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  bram_en,
    output logic [BYTE_NUM-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK
    } state_t;

    // RD_LAT is limited to 1..4, so three bits hold the countdown
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t     state;
    logic       last_gnt;
    logic       gnt;
    logic [2:0] lat_cnt;
    logic       req_any;
    logic       winner;

    // Pick this cycle's winner: a sole requester wins, a tie goes to the
    // master that was not granted last time.
    always_comb begin
        req_any = m0_req | m1_req;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~last_gnt;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            gnt       <= 1'b0;
            lat_cnt   <= '0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt       <= winner;
                        last_gnt  <= winner;
                        bram_en   <= 1'b1;
                        bram_we   <= winner ? m1_we    : m0_we;
                        bram_addr <= winner ? m1_addr  : m0_addr;
                        bram_din  <= winner ? m1_wdata : m0_wdata;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    bram_en <= 1'b0;
                    bram_we <= '0;
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        if (gnt) begin
                            m1_rdata <= bram_dout;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= bram_dout;
                            m0_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cfg_arb.sv
// tb_sys_cfg_arb: drives two masters into sys_cfg_arb (RD_LAT=1) backed by a
// read-first BRAM model, plus a second RD_LAT=3 instance with a ramping dout.
module tb_sys_cfg_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BN = 4;

    typedef struct {
        logic          mst;
        logic [BN-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic          mst;
        logic [DW-1:0] rdata;
    } sb_t;

    logic clk;
    logic rstn;

    logic          m0_req, m1_req;
    logic [BN-1:0] m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          bram_en;
    logic [BN-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          busy;

    logic          d3_m0_req;
    logic [BN-1:0] d3_m0_we;
    logic [AW-1:0] d3_m0_addr;
    logic [DW-1:0] d3_m0_wdata;
    logic          d3_m0_ack, d3_m1_ack;
    logic [DW-1:0] d3_m0_rdata, d3_m1_rdata;
    logic          d3_m1_req;
    logic [BN-1:0] d3_m1_we;
    logic [AW-1:0] d3_m1_addr;
    logic [DW-1:0] d3_m1_wdata;
    logic          d3_bram_en;
    logic [BN-1:0] d3_bram_we;
    logic [AW-1:0] d3_bram_addr;
    logic [DW-1:0] d3_bram_din;
    logic [DW-1:0] d3_bram_dout;
    logic          d3_busy;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_rd [2];
    sb_t           sb [$];
    vec_t          vecs [7];

    int checks;
    int errors;
    int n_ack;
    int m0_cnt;
    int m1_cnt;
    int ack_cyc [4];
    logic [DW-1:0] d3_seen;

    sys_cfg_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_NUM(BN), .RD_LAT(1)) u_dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy)
    );

    sys_cfg_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_NUM(BN), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata),
        .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata),
        .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .bram_en(d3_bram_en), .bram_we(d3_bram_we), .bram_addr(d3_bram_addr),
        .bram_din(d3_bram_din), .bram_dout(d3_bram_dout), .busy(d3_busy)
    );

    // free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // read-first BRAM model with one cycle of read latency
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr[5:2]];
            for (int b = 0; b < BN; b++) begin
                if (bram_we[b]) mem[bram_addr[5:2]][b*8 +: 8] <= bram_din[b*8 +: 8];
            end
        end
    end

    // the RD_LAT=3 instance sees a value that changes every cycle, so the
    // captured word pins down exactly which cycle was sampled
    always @(posedge clk) d3_bram_dout <= d3_bram_dout + 32'h0001_0001;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every ack must match the oldest expected transaction
    always @(negedge clk) begin
        sb_t e;
        if (rstn && (m0_ack || m1_ack)) begin
            checkOutput("ack_exclusive", 64'(m0_ack & m1_ack), 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ack_unexpected: got ack m0=%0d m1=%0d, expected none", m0_ack, m1_ack);
            end else begin
                e = sb.pop_front();
                checkOutput("ack_master", 64'(m1_ack), 64'(e.mst));
                checkOutput("ack_rdata", 64'(e.mst ? m1_rdata : m0_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_bram_en"},   64'(bram_en),   64'd0);
        checkOutput({tag, "_bram_we"},   64'(bram_we),   64'd0);
        checkOutput({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
        checkOutput({tag, "_bram_din"},  64'(bram_din),  64'd0);
        checkOutput({tag, "_acks"},      64'({m0_ack, m1_ack}), 64'd0);
        checkOutput({tag, "_m0_rdata"},  64'(m0_rdata),  64'd0);
        checkOutput({tag, "_m1_rdata"},  64'(m1_rdata),  64'd0);
        checkOutput({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // one complete single-master transaction, checked cycle by cycle from T
    task automatic applyStimulus(input vec_t v);
        if (v.mst) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        sb.push_back('{v.mst, v.exp_rdata});
        exp_rd[v.mst] = v.exp_rdata;
        @(posedge clk); #1;
        checkOutput("access_bram_en",   64'(bram_en),   64'd1);
        checkOutput("access_bram_we",   64'(bram_we),   64'(v.we));
        checkOutput("access_bram_addr", 64'(bram_addr), 64'(v.addr));
        checkOutput("access_bram_din",  64'(bram_din),  64'(v.wdata));
        checkOutput("access_busy",      64'(busy),      64'd1);
        @(posedge clk); #1;
        checkOutput("wait_bram_en", 64'(bram_en), 64'd0);
        checkOutput("wait_bram_we", 64'(bram_we), 64'd0);
        checkOutput("wait_acks",    64'({m0_ack, m1_ack}), 64'd0);
        @(posedge clk); #1;
        checkOutput("ack_own",     64'(v.mst ? m1_ack : m0_ack), 64'd1);
        checkOutput("ack_other",   64'(v.mst ? m0_ack : m1_ack), 64'd0);
        checkOutput("ack_bram_we", 64'(bram_we), 64'd0);
        checkOutput("ack_busy",    64'(busy), 64'd1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_busy",     64'(busy), 64'd0);
        checkOutput("idle_acks",     64'({m0_ack, m1_ack}), 64'd0);
        checkOutput("idle_bram_we",  64'(bram_we), 64'd0);
        checkOutput("hold_m0_rdata", 64'(m0_rdata), 64'(exp_rd[0]));
        checkOutput("hold_m1_rdata", 64'(m1_rdata), 64'(exp_rd[1]));
    endtask

    // hard stop if something wedges the bench
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 500 us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem[2] = 32'h1234_5678;
        bram_dout    = '0;
        d3_bram_dout = 32'hC0DE_0000;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // inputs, then the rdata the read-first BRAM returns for that access
        vecs[0] = '{1'b0, 4'hF,    32'h4, 32'hDEAD_BEEF, 32'h1000_0001};
        vecs[1] = '{1'b1, 4'h0,    32'h8, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 4'h0,    32'h4, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 4'b0011, 32'hC, 32'hAAAA_5555, 32'h1000_0003};
        vecs[4] = '{1'b1, 4'h0,    32'hC, 32'h0,         32'h1000_5555};
        vecs[5] = '{1'b1, 4'b1100, 32'h0, 32'h1234_ABCD, 32'h1000_0000};
        vecs[6] = '{1'b0, 4'h0,    32'h0, 32'h0,         32'h1234_0000};

        m0_req = 0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
        d3_m0_req = 0; d3_m0_we = '0; d3_m0_addr = '0; d3_m0_wdata = '0;
        d3_m1_req = 0; d3_m1_we = '0; d3_m1_addr = '0; d3_m1_wdata = '0;
        rstn = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // both masters request continuously: m0 first after reset, then alternate
        m0_req = 1; m0_we = '0; m0_addr = 32'h10;
        m1_req = 1; m1_we = '0; m1_addr = 32'h14;
        sb.push_back('{1'b0, 32'h1000_0004});
        sb.push_back('{1'b1, 32'h1000_0005});
        sb.push_back('{1'b0, 32'h1000_0004});
        sb.push_back('{1'b1, 32'h1000_0005});
        n_ack = 0; m0_cnt = 0; m1_cnt = 0;
        for (int k = 0; k < 4; k++) ack_cyc[k] = 0;
        for (int c = 1; c <= 40 && n_ack < 4; c++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) begin
                if (n_ack < 4) ack_cyc[n_ack] = c;
                n_ack++;
            end
            if (m0_ack) begin
                m0_cnt++;
                if (m0_cnt == 2) m0_req = 0;
            end
            if (m1_ack) begin
                m1_cnt++;
                if (m1_cnt == 2) m1_req = 0;
            end
        end
        checkOutput("rr_ack_count", 64'(n_ack), 64'd4);
        checkOutput("rr_first_ack_cycle", 64'(ack_cyc[0]), 64'd3);
        for (int k = 1; k < 4; k++) checkOutput("rr_ack_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd4);
        exp_rd[0] = 32'h1000_0004;
        exp_rd[1] = 32'h1000_0005;
        @(posedge clk); #1;
        checkOutput("rr_idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // RD_LAT=3 instance: ack at T+5 carrying the dout presented at T+4
        d3_m0_req = 1; d3_m0_we = '0; d3_m0_addr = 32'h20;
        @(posedge clk); #1;
        checkOutput("lat3_bram_en", 64'(d3_bram_en), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            checkOutput("lat3_early_ack", 64'(d3_m0_ack), 64'd0);
            checkOutput("lat3_wait_en",   64'(d3_bram_en), 64'd0);
        end
        d3_seen = d3_bram_dout;
        @(posedge clk); #1;
        checkOutput("lat3_ack",   64'(d3_m0_ack), 64'd1);
        checkOutput("lat3_rdata", 64'(d3_m0_rdata), 64'(d3_seen));
        checkOutput("lat3_m1_ack", 64'(d3_m1_ack), 64'd0);
        d3_m0_req = 0;
        @(posedge clk); #1;
        checkOutput("lat3_ack_pulse", 64'(d3_m0_ack), 64'd0);
        checkOutput("lat3_idle_busy", 64'(d3_busy), 64'd0);

        // reset during the WAIT of an m1 read drops it without an ack
        m1_req = 1; m1_we = '0; m1_addr = 32'h8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        m0_req = 1; m0_we = '0; m0_addr = 32'h4;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        sb.push_back('{1'b1, 32'h1234_5678});
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        n_ack = 0;
        for (int c = 1; c <= 30 && n_ack < 2; c++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) n_ack++;
            if (m0_ack) m0_req = 0;
            if (m1_ack) m1_req = 0;
        end
        checkOutput("midrst_ack_count", 64'(n_ack), 64'd2);
        @(posedge clk); #1;
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
